// File: rtl/mux_nto1_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared mode constants and output-stage state encoding for
//               mux_nto1_rr.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic c_mode_fixed_unused = 1'b0;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_nto1_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first requester strictly
//               after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int SELW = $clog2(N);

    int w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        w_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(ptr) + k) % N;
            if (req[w_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(w_idx);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_rr
// Description : N:1 valid/ready channel mux, fixed-select or round-robin,
//               with one registered output stage. Optional macro
//               MUX_STATS_EN adds a 16-bit output handshake counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_chan,
    input  logic                 out_ready
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    localparam int SELW = $clog2(N);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_out_data;
    logic [SELW-1:0]   r_out_chan;
    logic [SELW-1:0]   r_rr_ptr;

    logic              w_load_en;
    logic              w_xfer;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_rr_any;
    logic [SELW-1:0]   w_fix_idx;
    logic              w_fix_any;
    logic [SELW-1:0]   w_gnt_idx;
    logic              w_gnt_any;
    logic [W-1:0]      w_gnt_data;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
    );

    // An out-of-range sel matches no channel, so it simply yields no grant.
    always_comb begin
        w_fix_any = 1'b0;
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                w_fix_any = 1'b1;
                w_fix_idx = SELW'(i);
            end
        end
    end

    assign w_gnt_any = (mode == MODE_RR) ? w_rr_any : w_fix_any;
    assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : w_fix_idx;
    assign w_load_en = (r_state == EMPTY) || out_ready;
    assign w_xfer    = w_load_en && w_gnt_any;

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data = in_data[i*W +: W];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = w_xfer && (w_gnt_idx == SELW'(gi));
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = FULL;
        end else if (out_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_rr_ptr   <= SELW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_out_data <= w_gnt_data;
                r_out_chan <= w_gnt_idx;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= w_gnt_idx;
                end
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

`ifdef MUX_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule : mux_nto1_rr
`default_nettype wire

// File: tb/tb_mux_nto1_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_rr
// Description : Scoreboard bench for mux_nto1_rr (N=4, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [1:0]   out_chan;
    logic         out_ready;
`ifdef MUX_STATS_EN
    logic [15:0]  xfer_cnt;
`endif

    mux_nto1_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
`ifdef MUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q [$];
    logic [1:0]  chan_log [$];
    bit          m_full;
    int          m_ptr;
    int          m_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(output int g, output bit any);
        g   = 0;
        any = 1'b0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                g   = int'(sel);
                any = 1'b1;
            end
        end else begin
            for (int k = 1; k <= N && !any; k++) begin
                if (in_valid[(m_ptr + k) % N]) begin
                    g   = (m_ptr + k) % N;
                    any = 1'b1;
                end
            end
        end
    endtask

    // One clock: check combinational/registered outputs mid-cycle, advance model.
    task automatic cycle();
        int          g;
        bit          any;
        bit          load;
        logic [3:0]  exp_rdy;
        logic [15:0] e;
        @(negedge clk);
        model_grant(g, any);
        load    = !m_full || out_ready;
        exp_rdy = (load && any) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full && out_ready) begin
            m_hs++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[7:0]));
                check("out_chan", 32'(out_chan), 32'(e[15:8]));
                chan_log.push_back(out_chan);
            end
        end
        if (load && any) begin
            exp_q.push_back({8'(g), in_data[g*8 +: 8]});
            if (mode) m_ptr = g;
            m_full = 1'b1;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
        m_full = 1'b0; m_ptr = N - 1; m_hs = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        rst = 1'b0;

        // Fixed select of channel 2, then a sel whose channel is idle.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data[23:16] = 8'hA5;
        cycle();
        sel = 2'd1; in_valid = 4'b1101;
        cycle();
        cycle();
        in_data[23:16] = 8'h12;

        // Round-robin fairness from reset pointer.
        mode = 1'b1; in_valid = 4'b1111;
        chan_log.delete();
        repeat (6) cycle();
        check("rr_log_size", 32'(chan_log.size()), 32'd5);
        if (chan_log.size() >= 5) begin
            check("rr_seq0", 32'(chan_log[0]), 32'd0);
            check("rr_seq1", 32'(chan_log[1]), 32'd1);
            check("rr_seq2", 32'(chan_log[2]), 32'd2);
            check("rr_seq3", 32'(chan_log[3]), 32'd3);
            check("rr_seq4", 32'(chan_log[4]), 32'd0);
        end

        // Pointer now at 1: sparse requests 3 and 1 alternate.
        in_valid = 4'b1010;
        chan_log.delete();
        repeat (4) cycle();
        check("skip_log_size", 32'(chan_log.size()), 32'd4);
        if (chan_log.size() >= 4) begin
            check("skip0", 32'(chan_log[1]), 32'd3);
            check("skip1", 32'(chan_log[2]), 32'd1);
            check("skip2", 32'(chan_log[3]), 32'd3);
        end

        // Back-pressure: register holds channel 1's word.
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_data", 32'(out_data), 32'h11);
            check("bp_chan", 32'(out_chan), 32'd1);
        end
        out_ready = 1'b1;
        repeat (3) cycle();

`ifdef MUX_STATS_EN
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_hs));
`endif

        // Load channel 3, then reset asynchronously between edges.
        in_valid = 4'b1000;
        cycle();
        check("pre_rst_chan", 32'(out_chan), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_chan", 32'(out_chan), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
`ifdef MUX_STATS_EN
        check("async_rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
        exp_q.delete();
        m_full = 1'b0; m_ptr = N - 1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset channel 0 wins the first round-robin grant.
        in_valid = 4'b1111;
        cycle();
        check("post_rst_chan", 32'(out_chan), 32'd0);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_nto1_rr
`default_nettype wire
